// File: rtl/ysyx_24120013_inst_mem.sv
// Instruction-memory responder: valid/ready fetch channel in, registered instruction out after LATENCY cycles.
// Optional address fault checking is enabled by defining YSYX_24120013_IMEM_ERR_CHK_EN.
module ysyx_24120013_inst_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 'h8000_0000,
  parameter int                    LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic                    err_q, err_d;
  logic                    req_ready_q, req_ready_d;
  logic [ADDR_WIDTH-1:0]   fetch_addr;
  logic                    fetch_fault;
  logic                    ld_fault;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE) >> 2);
  endfunction

`ifdef YSYX_24120013_IMEM_ERR_CHK_EN
  // One extra bit so BASE + 4*DEPTH cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] BASE_X = {1'b0, BASE};
  localparam logic [ADDR_WIDTH:0] LIMIT  = BASE_X + (ADDR_WIDTH + 1)'(DEPTH * 4);

  function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} < BASE_X) || ({1'b0, a} >= LIMIT);
  endfunction

  assign fetch_fault = addr_fault(fetch_addr);
  assign ld_fault    = addr_fault(ld_addr);
`else
  assign fetch_fault = 1'b0;
  assign ld_fault    = 1'b0;
`endif

  // With LATENCY == 1 the lookup happens on the accept edge, before addr_q holds the address.
  assign fetch_addr = (state_q == IDLE) ? req_addr : addr_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reads the array value before any same-edge loader write lands: collisions return old data.
    if (state_d == RESP && state_q != RESP) begin
      inst_d = fetch_fault ? '0 : mem_q[word_idx(fetch_addr)];
      err_d  = fetch_fault;
    end
    req_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking is reserved for always_comb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
    end
  end

  // NOTE: the array has no reset; contents come only from the loader port.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_fault) mem_q[word_idx(ld_addr)] <= ld_data;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24120013_inst_mem.sv
// Scoreboard bench for ysyx_24120013_inst_mem: three instances with LATENCY 1, 3 and 4 share one loader.
// Expectations follow YSYX_24120013_IMEM_ERR_CHK_EN when it is defined for the build.
module tb_ysyx_24120013_inst_mem;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid_v;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  req_ready_v;
  logic [2:0]  rsp_valid_v;
  logic [2:0]  rsp_err_v;
  logic [31:0] rsp_inst_v [3];

  logic [31:0] model [DEPTH];
  exp_t        sb [$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_24120013_inst_mem #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .DEPTH     (DEPTH),
      .BASE      (BASE),
      .LATENCY   (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid_v[g]),
      .req_ready(req_ready_v[g]),
      .req_addr (req_addr),
      .rsp_valid(rsp_valid_v[g]),
      .rsp_ready(rsp_ready),
      .rsp_inst (rsp_inst_v[g]),
      .rsp_err  (rsp_err_v[g]),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data)
    );
  end

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 3 : 4);
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
`ifdef YSYX_24120013_IMEM_ERR_CHK_EN
    return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(4 * DEPTH));
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[IDX_W+1:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if (!is_fault(a)) model[idx_of(a)] = d;
  endtask

  // One transaction on instance sel. hold > 0 applies backpressure for that many cycles while a
  // stray request is kept asserted; coll writes cdata to the same word on the edge entering RESP.
  task automatic fetch(input int sel, input logic [31:0] a, input int hold,
                       input logic coll, input logic [31:0] cdata);
    exp_t        e;
    int          n;
    int          lat;
    logic [31:0] held;
    lat = lat_of(sel);
    @(negedge clk);
    check($sformatf("ready_idle[%0d]", sel), 32'(req_ready_v[sel]), 32'd1);
    rsp_ready   = (hold == 0);
    req_valid_v = 3'(1 << sel);
    req_addr    = a;
    e.err  = is_fault(a);
    e.inst = e.err ? 32'd0 : model[idx_of(a)];
    sb.push_back(e);
    if (coll && !is_fault(a)) model[idx_of(a)] = cdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req_addr = a + 32'h8;
      if (coll && n == lat - 1) begin
        ld_en = 1'b1; ld_addr = a; ld_data = cdata;
      end else begin
        ld_en = 1'b0;
      end
      if (!rsp_valid_v[sel]) check($sformatf("ready_busy[%0d]", sel), 32'(req_ready_v[sel]), 32'd0);
    end while (!rsp_valid_v[sel] && n < 40);
    check($sformatf("latency[%0d]", sel), 32'(n), 32'(lat));
    if (hold == 0) req_valid_v = '0;
    if (rsp_valid_v[sel]) begin
      held = rsp_inst_v[sel];
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check($sformatf("bp_valid[%0d]", sel), 32'(rsp_valid_v[sel]), 32'd1);
        check($sformatf("bp_inst[%0d]", sel), rsp_inst_v[sel], held);
        check($sformatf("bp_ready[%0d]", sel), 32'(req_ready_v[sel]), 32'd0);
      end
      req_valid_v = '0;
      rsp_ready   = 1'b1;
      e = sb.pop_front();
      check($sformatf("inst[%0d]@%08h", sel, a), rsp_inst_v[sel], e.inst);
      check($sformatf("err[%0d]@%08h", sel, a), 32'(rsp_err_v[sel]), 32'(e.err));
      @(negedge clk);
      check($sformatf("ready_after[%0d]", sel), 32'(req_ready_v[sel]), 32'd1);
      check($sformatf("valid_after[%0d]", sel), 32'(rsp_valid_v[sel]), 32'd0);
    end else begin
      req_valid_v = '0;
      rsp_ready   = 1'b1;
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    rst = 1'b0; req_valid_v = '0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready_v), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_v), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_v), 32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("rst_inst[%0d]", i), rsp_inst_v[i], 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(req_ready_v), 32'd7);

    load(BASE,                   32'h0000_0413);
    load(BASE + 32'h4,           32'h0010_0093);
    load(BASE + 32'(4 * 1023),   32'h1357_9BDF);

    fetch(0, BASE + 32'h4, 0, 1'b0, '0);
    fetch(2, BASE + 32'h4, 0, 1'b0, '0);
    fetch(2, BASE,         5, 1'b0, '0);
    fetch(1, BASE + 32'h4, 0, 1'b0, '0);
    fetch(0, BASE,         0, 1'b0, '0);

    fetch(0, BASE + 32'h2,    0, 1'b0, '0);
    fetch(2, BASE + 32'h1000, 0, 1'b0, '0);
    fetch(1, BASE - 32'h4,    0, 1'b0, '0);

    // Reset asserted while the LATENCY=3 instance sits in WAIT.
    @(negedge clk);
    req_valid_v = 3'b010; req_addr = BASE;
    @(negedge clk);
    req_valid_v = '0;
    check("wait_ready", 32'(req_ready_v[1]), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready_v), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid_v), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_valid", 32'(rsp_valid_v), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_valid_%0d", i), 32'(rsp_valid_v), 32'd0);
      check($sformatf("post_rst_ready_%0d", i), 32'(req_ready_v), 32'd7);
    end

    load(BASE + 32'h8, 32'hCAFE_0001);
    fetch(1, BASE + 32'h8, 0, 1'b1, 32'hDEAD_BEEF);
    fetch(1, BASE + 32'h8, 0, 1'b0, '0);

    load(BASE + 32'h2, 32'h1234_5678);
    fetch(0, BASE, 0, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      ra = BASE + {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      rd = $urandom;
      load(ra, rd);
      fetch(i % 3, ra, i % 2, 1'b0, '0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
